// File: rtl/data_mem_responder_if.sv
// CPU data-memory request/response bundle: one load/store request channel and
// one response channel, each with a valid/ready handshake.
interface data_mem_responder_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [2:0]  req_funct3_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  modport slave (
    input  req_valid_i,
    input  req_we_i,
    input  req_addr_i,
    input  req_wdata_i,
    input  req_funct3_i,
    input  rsp_ready_i,
    output req_ready_o,
    output rsp_valid_o,
    output rsp_rdata_o,
    output rsp_err_o
  );

  modport master (
    output req_valid_i,
    output req_we_i,
    output req_addr_i,
    output req_wdata_i,
    output req_funct3_i,
    output rsp_ready_i,
    input  req_ready_o,
    input  rsp_valid_o,
    input  rsp_rdata_o,
    input  rsp_err_o
  );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding RV32I data memory responder with programmable wait states,
// byte/halfword/word access, load extension and fault reporting.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input logic                 clk_i,
  input logic                 reset_i,
  data_mem_responder_if.slave bus
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic       NO_WAIT   = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Fault rule: illegal funct3 for the direction, misaligned half/word, or beyond the array.
  function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    logic legal;
    logic misal;
    logic oor;
    if (we) begin
      legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    end else begin
      legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
              (f3 == 3'b100) || (f3 == 3'b101);
    end
    case (f3[1:0])
      2'b01:   misal = addr[0];
      2'b10:   misal = (addr[1:0] != 2'b00);
      default: misal = 1'b0;
    endcase
    oor = ((addr >> (AW + 2)) != 32'd0);
    return !legal || misal || oor;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_lanes(input logic [2:0] f3, input logic [1:0] lane);
    logic [3:0] be;
    case (f3)
      3'b000:  be = 4'b0001 << lane;
      3'b001:  be = lane[1] ? 4'b1100 : 4'b0011;
      3'b010:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wdata);
    logic [31:0] d;
    case (f3)
      3'b000:  d = {4{wdata[7:0]}};
      3'b001:  d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        ready_s;
  logic        accept_s;
  logic        commit_s;
  logic        handshake_s;
  logic [31:0] acc_addr_s;
  logic [31:0] acc_wdata_s;
  logic        acc_we_s;
  logic [2:0]  acc_f3_s;
  logic        acc_err_s;
  logic [AW-1:0] idx_s;
  logic [31:0] word_s;
  logic [31:0] load_s;
  logic [3:0]  be_s;
  logic [31:0] st_data_s;
  logic        mem_we_s;

  // Contents are deliberately left unreset.
  logic [31:0] mem_array [DEPTH_WORDS];

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = NO_WAIT ? ST_RESP : ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (handshake_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake qualifiers and the single commit strobe
  always_comb begin
    ready_s     = (state_q == ST_IDLE) && !reset_i;
    accept_s    = bus.req_valid_i && ready_s;
    handshake_s = (state_q == ST_RESP) && bus.rsp_ready_i;
    case (state_q)
      ST_IDLE: commit_s = accept_s && NO_WAIT;
      ST_WAIT: commit_s = (cnt_q == 4'd0);
      default: commit_s = 1'b0;
    endcase
  end

  // With zero wait states the access commits on the accept edge, straight from the bus.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_addr_s  = bus.req_addr_i;
      acc_wdata_s = bus.req_wdata_i;
      acc_we_s    = bus.req_we_i;
      acc_f3_s    = bus.req_funct3_i;
    end else begin
      acc_addr_s  = addr_q;
      acc_wdata_s = wdata_q;
      acc_we_s    = we_q;
      acc_f3_s    = funct3_q;
    end
    idx_s     = acc_addr_s[AW+1:2];
    word_s    = mem_array[idx_s];
    acc_err_s = access_err(acc_we_s, acc_f3_s, acc_addr_s);
    load_s    = load_extend(acc_f3_s, acc_addr_s[1:0], word_s);
    be_s      = store_lanes(acc_f3_s, acc_addr_s[1:0]);
    st_data_s = store_data(acc_f3_s, acc_wdata_s);
    mem_we_s  = commit_s && acc_we_s && !acc_err_s && !reset_i;
  end

  // Request capture, wait counter and response data
  always_comb begin
    if (accept_s) begin
      addr_d   = bus.req_addr_i;
      wdata_d  = bus.req_wdata_i;
      we_d     = bus.req_we_i;
      funct3_d = bus.req_funct3_i;
      cnt_d    = WAIT_LOAD;
    end else begin
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      we_d     = we_q;
      funct3_d = funct3_q;
      if ((state_q == ST_WAIT) && (cnt_q != 4'd0)) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        cnt_d = cnt_q;
      end
    end
    rsp_valid_d = (state_d == ST_RESP);
    if (commit_s) begin
      rdata_d = (acc_err_s || acc_we_s) ? 32'd0 : load_s;
      err_d   = acc_err_s;
    end else begin
      rdata_d = rdata_q;
      err_d   = err_q;
    end
  end

  // Captured request and registered response
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      we_q        <= 1'b0;
      funct3_q    <= 3'd0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Byte-lane write into the array
  always_ff @(posedge clk_i) begin
    if (mem_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_array[idx_s][8*i +: 8] <= st_data_s[8*i +: 8];
        end
      end
    end
  end

  assign bus.req_ready_o = ready_s;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_err_o   = err_q;

endmodule
